// File: rtl/scanner_status_monitor_if.sv
// Status bundle published by the scanner: dispatch/evaluate activity and readiness
// for a new scan. The consumer modport is what monitors and LED logic attach to.
interface i_scanner_status;
  logic dispatching;
  logic evaluating;
  logic ready;

  modport master   (output dispatching, evaluating, ready);
  modport slave    (input  dispatching, evaluating, ready);
  modport consumer (input  dispatching, evaluating, ready);
endinterface

// File: rtl/scanner_status_monitor.sv
// Downstream monitor for a scanner: gates host start requests, tracks the scan
// lifecycle, stretches evaluate strobes for an LED and measures evaluations per window.
module scanner_status_monitor #(
  parameter int unsigned WINDOW_CYCLES  = 100_000_000,
  parameter int unsigned STRETCH_CYCLES = 2_000_000,
  parameter int unsigned ARM_TIMEOUT    = 1024,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  i_scanner_status.consumer    status,
  input  logic                 start_req,
  output logic                 start,
  output logic                 busy,
  output logic                 led_ready,
  output logic                 led_scanning,
  output logic                 led_activity,
  output logic                 arm_timeout_err,
  output logic [CNT_W-1:0]     hashes_per_window,
  output logic                 window_valid,
  output logic [CNT_W-1:0]     eval_total
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  localparam int STR_W = $clog2(STRETCH_CYCLES + 1);
  localparam int ARM_W = $clog2(ARM_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH_CYCLES);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    SCANNING = 2'd2,
    FLUSHING = 2'd3
  } state_t;

  state_t             state_q;
  logic [ARM_W-1:0]   arm_cnt_q;
  logic               start_q;
  logic               busy_q;
  logic               scanning_q;
  logic               arm_err_q;
  logic               led_ready_q;

  logic [STR_W-1:0]   stretch_q,  stretch_d;
  logic               activity_q, activity_d;
  logic [WIN_W-1:0]   win_pos_q,  win_pos_d;
  logic [CNT_W-1:0]   win_cnt_q,  win_cnt_d;
  logic [CNT_W-1:0]   hpw_q,      hpw_d;
  logic               wv_q,       wv_d;
  logic [CNT_W-1:0]   total_q,    total_d;
  logic [CNT_W-1:0]   win_cnt_inc;

  // Lifecycle FSM; busy/led_scanning are registered alongside the state so they
  // change on the same edge as the transition that implies them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      arm_cnt_q  <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      scanning_q <= 1'b0;
      arm_err_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_req && status.ready) begin
            start_q   <= 1'b1;
            busy_q    <= 1'b1;
            arm_cnt_q <= '0;
            state_q   <= ARMED;
          end
        end
        ARMED: begin
          if (status.dispatching) begin
            scanning_q <= 1'b1;
            state_q    <= SCANNING;
          end else if (arm_cnt_q == ARM_LAST) begin
            busy_q    <= 1'b0;
            arm_err_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            arm_cnt_q <= arm_cnt_q + ARM_W'(1);
          end
        end
        SCANNING: begin
          if (!status.dispatching) begin
            scanning_q <= 1'b0;
            state_q    <= FLUSHING;
          end
        end
        FLUSHING: begin
          if (status.ready) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q     <= 1'b0;
          scanning_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stretch_d = stretch_q;
    if (status.evaluating) begin
      stretch_d = STR_LOAD;
    end else if (stretch_q != '0) begin
      stretch_d = stretch_q - STR_W'(1);
    end
    // The counter value 1 marks the last lit cycle, so the LED drops on the next edge.
    activity_d = status.evaluating || (stretch_q > STR_W'(1));

    win_cnt_inc = (status.evaluating && (win_cnt_q != CNT_MAX)) ? win_cnt_q + CNT_W'(1) : win_cnt_q;
    hpw_d       = hpw_q;
    wv_d        = 1'b0;
    if (win_pos_q == WIN_LAST) begin
      win_pos_d = '0;
      win_cnt_d = '0;
      hpw_d     = win_cnt_inc;
      wv_d      = 1'b1;
    end else begin
      win_pos_d = win_pos_q + WIN_W'(1);
      win_cnt_d = win_cnt_inc;
    end

    total_d = (status.evaluating && (total_q != CNT_MAX)) ? total_q + CNT_W'(1) : total_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_ready_q <= 1'b0;
      stretch_q   <= '0;
      activity_q  <= 1'b0;
      win_pos_q   <= '0;
      win_cnt_q   <= '0;
      hpw_q       <= '0;
      wv_q        <= 1'b0;
      total_q     <= '0;
    end else begin
      led_ready_q <= status.ready;
      stretch_q   <= stretch_d;
      activity_q  <= activity_d;
      win_pos_q   <= win_pos_d;
      win_cnt_q   <= win_cnt_d;
      hpw_q       <= hpw_d;
      wv_q        <= wv_d;
      total_q     <= total_d;
    end
  end

  assign start             = start_q;
  assign busy              = busy_q;
  assign led_ready         = led_ready_q;
  assign led_scanning      = scanning_q;
  assign led_activity      = activity_q;
  assign arm_timeout_err   = arm_err_q;
  assign hashes_per_window = hpw_q;
  assign window_valid      = wv_q;
  assign eval_total        = total_q;

endmodule

// File: tb/tb_scanner_status_monitor.sv
// Randomized bench for scanner_status_monitor: a cycle-indexed reference model pushes
// expected outputs into queues; a negedge monitor pops and compares.
module tb_scanner_status_monitor;

  localparam int W    = 18;
  localparam int S    = 4;
  localparam int T    = 8;
  localparam int CW   = 4;
  localparam int MAXV = (1 << CW) - 1;

  localparam int P_IDLE  = 0;
  localparam int P_ARMED = 1;
  localparam int P_SCAN  = 2;
  localparam int P_FLUSH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_req = 1'b0;
  logic start, busy, led_ready, led_scanning, led_activity, arm_timeout_err, window_valid;
  logic [CW-1:0] hashes_per_window, eval_total;

  i_scanner_status st();

  scanner_status_monitor #(
    .WINDOW_CYCLES (W),
    .STRETCH_CYCLES(S),
    .ARM_TIMEOUT   (T),
    .CNT_W         (CW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .status           (st),
    .start_req        (start_req),
    .start            (start),
    .busy             (busy),
    .led_ready        (led_ready),
    .led_scanning     (led_scanning),
    .led_activity     (led_activity),
    .arm_timeout_err  (arm_timeout_err),
    .hashes_per_window(hashes_per_window),
    .window_valid     (window_valid),
    .eval_total       (eval_total)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          start;
    logic          busy;
    logic          led_ready;
    logic          led_scanning;
    logic          led_activity;
    logic          err;
    logic          wv;
    logic [CW-1:0] hpw;
    logic [CW-1:0] total;
  } obs_t;

  obs_t exp_q[$];
  int   win_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state, indexed by cycles since reset release.
  int phase, armed_cycles, cyc, last_eval, win_raw, total_raw, hpw_m;
  bit err_m;
  bit disp_lvl;

  function automatic obs_t sample();
    obs_t a;
    a.start        = start;
    a.busy         = busy;
    a.led_ready    = led_ready;
    a.led_scanning = led_scanning;
    a.led_activity = led_activity;
    a.err          = arm_timeout_err;
    a.wv           = window_valid;
    a.hpw          = hashes_per_window;
    a.total        = eval_total;
    return a;
  endfunction

  function automatic int clampv(int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic model_reset();
    phase = P_IDLE; armed_cycles = 0; cyc = 0; last_eval = -1000;
    win_raw = 0; total_raw = 0; hpw_m = 0; err_m = 1'b0;
  endtask

  // Evaluates the clock edge just taken, using the inputs the DUT sampled on it.
  task automatic model_step();
    obs_t e;
    e = '0;
    case (phase)
      P_IDLE: if (start_req && st.ready) begin
        e.start = 1'b1; phase = P_ARMED; armed_cycles = 0;
      end
      P_ARMED: begin
        armed_cycles++;
        if (st.dispatching) phase = P_SCAN;
        else if (armed_cycles == T) begin phase = P_IDLE; err_m = 1'b1; end
      end
      P_SCAN:  if (!st.dispatching) phase = P_FLUSH;
      default: if (st.ready) phase = P_IDLE;
    endcase
    e.busy         = (phase != P_IDLE);
    e.led_scanning = (phase == P_SCAN);
    e.err          = err_m;
    e.led_ready    = st.ready;
    if (st.evaluating) begin
      last_eval = cyc; win_raw++; total_raw++;
    end
    e.led_activity = ((cyc + 1 - last_eval) <= S);
    if ((cyc % W) == W - 1) begin
      hpw_m = clampv(win_raw); win_raw = 0; e.wv = 1'b1;
      win_q.push_back(hpw_m);
    end
    e.hpw   = CW'(hpw_m);
    e.total = CW'(clampv(total_raw));
    cyc++;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int mode);
    case (mode)
      1: begin  // dispatch never rises: forces arm timeouts
        st.dispatching = 1'b0; st.ready = 1'($urandom % 2);
        start_req = 1'b1; st.evaluating = ($urandom % 4) == 0;
      end
      2: begin  // evaluate flood
        st.evaluating = 1'b1; st.ready = 1'($urandom % 2);
        st.dispatching = 1'($urandom % 2); start_req = 1'($urandom % 2);
      end
      3: begin  // sparse evaluations
        st.evaluating = ($urandom % 10) == 0; st.ready = 1'($urandom % 2);
        st.dispatching = 1'($urandom % 2); start_req = 1'($urandom % 2);
      end
      4: begin  // long scans
        if (($urandom % 12) == 0) disp_lvl = ~disp_lvl;
        st.dispatching = disp_lvl; st.ready = ($urandom % 4) != 0;
        start_req = ($urandom % 8) != 0;
        st.evaluating = disp_lvl ? 1'($urandom % 2) : (($urandom % 4) == 0);
      end
      default: begin
        st.ready = 1'($urandom % 2); st.dispatching = 1'($urandom % 2);
        st.evaluating = 1'($urandom % 2); start_req = ($urandom % 4) != 0;
      end
    endcase
  endtask

  task automatic run_cycles(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1 drive(mode);
    end
  endtask

  task automatic check_zero(input string name);
    obs_t a;
    a = sample();
    checks++;
    if (a !== obs_t'(0)) begin
      errors++;
      $display("FAIL %s t=%0t got=%h required=0", name, $time, a);
    end
  endtask

  // Asynchronous reset asserted mid-cycle, preferably while a scan is in progress.
  task automatic do_reset();
    int n;
    n = 0;
    while (phase != P_SCAN && n < 200) begin
      run_cycles(1, 4);
      n++;
    end
    @(posedge clk);
    model_step();
    #2 rst_n = 1'b0;
    exp_q.delete();
    win_q.delete();
    exp_q.push_back('0);
    #1 check_zero("async_reset_outputs");
    $display("reset asserted t=%0t in_scan=%0d", $time, phase == P_SCAN);
    model_reset();
    repeat (2) begin
      @(posedge clk);
      exp_q.push_back('0);
    end
    #1 rst_n = 1'b1;
    drive($urandom % 5);
  endtask

  // Monitor: one expected snapshot per cycle, plus window results on window_valid.
  initial begin
    obs_t e, a;
    int   ew;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = sample();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t got start=%b busy=%b rdy=%b scan=%b act=%b err=%b wv=%b hpw=%0d tot=%0d required start=%b busy=%b rdy=%b scan=%b act=%b err=%b wv=%b hpw=%0d tot=%0d",
                   $time, a.start, a.busy, a.led_ready, a.led_scanning, a.led_activity, a.err, a.wv, a.hpw, a.total,
                   e.start, e.busy, e.led_ready, e.led_scanning, e.led_activity, e.err, e.wv, e.hpw, e.total);
        end
      end
      if (window_valid === 1'b1) begin
        checks++;
        if (win_q.size() == 0) begin
          errors++;
          $display("FAIL window_unexpected t=%0t got hashes=%0d required no window", $time, hashes_per_window);
        end else begin
          ew = win_q.pop_front();
          if (hashes_per_window !== CW'(ew)) begin
            errors++;
            $display("FAIL window_value t=%0t got hashes=%0d required %0d", $time, hashes_per_window, ew);
          end else begin
            $display("window t=%0t hashes=%0d", $time, hashes_per_window);
          end
        end
      end
    end
  end

  initial begin
    st.ready = 1'b0; st.dispatching = 1'b0; st.evaluating = 1'b0;
    disp_lvl = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_zero("power_on_reset");
    repeat (3) begin
      @(posedge clk);
      exp_q.push_back('0);
    end
    // Release with a request already pending: start must fire on the first edge.
    #1 st.ready = 1'b1; start_req = 1'b1; rst_n = 1'b1;

    for (int seg = 0; seg < 30; seg++) begin
      run_cycles(40 + ($urandom % 80), $urandom % 5);
      if ((seg % 6) == 5) do_reset();
    end

    @(posedge clk);
    model_step();
    #6;
    checks++;
    if (exp_q.size() != 0 || win_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got pending=%0d/%0d required 0/0", exp_q.size(), win_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
